// File: rtl/voice_pkg.sv
// Shared constants, FSM state encoding and scan-index helper for the voice allocator.
package voice_pkg;

  localparam int NUM_KEYS   = 32;
  localparam int NUM_VOICES = 4;
  localparam int NOTE_W     = 5;
  localparam int VOICE_W    = 2;
  localparam int RANK_W     = 2;

  typedef enum logic [1:0] {
    S_SCAN    = 2'd0,
    S_PRESS   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  typedef logic [NOTE_W-1:0]  note_t;
  typedef logic [VOICE_W-1:0] voice_t;

  // Scan index advance with wrap at the last key.
  function automatic note_t next_idx(input note_t idx, input int unsigned num_keys);
    return (idx == NOTE_W'(num_keys - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/voice_lru.sv
// LRU age tracker: rank 0 is the most recently allocated voice, the top rank is the oldest.
module voice_lru
  import voice_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         alloc,
  input  voice_t       voice_id,
  output voice_t       oldest
);

  logic [RANK_W-1:0] rank [NUM_VOICES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_VOICES; n++) begin
        rank[n] <= RANK_W'(n);
      end
    end else if (alloc) begin
      // Voices younger than the allocated one age by one; the allocated one becomes youngest.
      for (int n = 0; n < NUM_VOICES; n++) begin
        if (voice_id == VOICE_W'(n)) begin
          rank[n] <= '0;
        end else if (rank[n] < rank[voice_id]) begin
          rank[n] <= rank[n] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    oldest = '0;
    for (int n = 0; n < NUM_VOICES; n++) begin
      if (rank[n] == RANK_W'(NUM_VOICES - 1)) begin
        oldest = VOICE_W'(n);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Key scanner and polyphonic voice allocator with LRU stealing and an Avalon-MM read port.
module voice_allocator #(
  parameter int NUM_KEYS   = voice_pkg::NUM_KEYS,
  parameter int NUM_VOICES = voice_pkg::NUM_VOICES
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_KEYS-1:0]                    key_state,
  input  logic                                   scan_en,
  input  logic                                   all_off,
  output logic [NUM_VOICES*voice_pkg::NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]                  voice_gate,
  output logic [NUM_VOICES-1:0]                  voice_trig,
  input  logic [1:0]                             address,
  output logic [31:0]                            readdata
);

  import voice_pkg::*;

  state_t                state, state_nxt;
  note_t                 idx, idx_nxt;
  logic [NUM_KEYS-1:0]   prev_key;
  note_t                 note [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate;
  logic [NUM_VOICES-1:0] trig;

  logic                  has_free;
  voice_t                free_id;
  voice_t                oldest;
  voice_t                alloc_id;
  logic                  alloc;
  logic [NUM_VOICES-1:0] rel_match;

  // A press is committed only when the panic input does not override it.
  assign alloc    = (state == S_PRESS) && !all_off;
  assign alloc_id = has_free ? free_id : oldest;

  always_comb begin
    has_free = 1'b0;
    free_id  = '0;
    for (int n = NUM_VOICES - 1; n >= 0; n--) begin
      if (!gate[n]) begin
        has_free = 1'b1;
        free_id  = VOICE_W'(n);
      end
    end
  end

  always_comb begin
    rel_match = '0;
    for (int n = 0; n < NUM_VOICES; n++) begin
      rel_match[n] = gate[n] && (note[n] == idx);
    end
  end

  voice_lru u_lru (
    .clk      (clk),
    .reset_n  (reset_n),
    .alloc    (alloc),
    .voice_id (alloc_id),
    .oldest   (oldest)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      S_SCAN: begin
        if (scan_en) begin
          if (key_state[idx] && !prev_key[idx]) begin
            state_nxt = S_PRESS;
          end else if (!key_state[idx] && prev_key[idx]) begin
            state_nxt = S_RELEASE;
          end else begin
            idx_nxt = next_idx(idx, NUM_KEYS);
          end
        end
      end
      S_PRESS, S_RELEASE: begin
        state_nxt = S_SCAN;
        idx_nxt   = next_idx(idx, NUM_KEYS);
      end
      default: state_nxt = S_SCAN;
    endcase
    // Panic returns to scanning but keeps the scan position.
    if (all_off) begin
      state_nxt = S_SCAN;
      idx_nxt   = idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_SCAN;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_key <= '0;
      gate     <= '0;
      trig     <= '0;
      for (int n = 0; n < NUM_VOICES; n++) begin
        note[n] <= '0;
      end
    end else begin
      trig <= '0;
      if (all_off) begin
        gate     <= '0;
        prev_key <= '0;
      end else if (state == S_PRESS) begin
        prev_key[idx]  <= 1'b1;
        note[alloc_id] <= idx;
        gate[alloc_id] <= 1'b1;
        trig[alloc_id] <= 1'b1;
      end else if (state == S_RELEASE) begin
        // A stolen key finds no matching voice, so nothing but prev_key changes.
        prev_key[idx] <= 1'b0;
        gate          <= gate & ~rel_match;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= {26'b0, gate[address], note[address]};
    end
  end

  always_comb begin
    voice_note = '0;
    for (int n = 0; n < NUM_VOICES; n++) begin
      voice_note[n*NOTE_W +: NOTE_W] = note[n];
    end
  end

  assign voice_gate = gate;
  assign voice_trig = trig;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: vector table of key patterns plus hand-written reset/scan/panic sequences.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] key_state;
  logic        scan_en;
  logic        all_off;
  logic [1:0]  address;
  logic [19:0] voice_note;
  logic [3:0]  voice_gate;
  logic [3:0]  voice_trig;
  logic [31:0] readdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_q [$];

  typedef struct {
    logic [31:0] keys;
    logic [3:0]  gate;
    logic [19:0] notes;
    int          trigs;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  voice_allocator dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_state  (key_state),
    .scan_en    (scan_en),
    .all_off    (all_off),
    .voice_note (voice_note),
    .voice_gate (voice_gate),
    .voice_trig (voice_trig),
    .address    (address),
    .readdata   (readdata)
  );

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [4:0] note_of(input int v);
    return voice_note[v*5 +: 5];
  endfunction

  task automatic settle(input int n, output int trigs);
    trigs = 0;
    repeat (n) begin
      @(posedge clk); #1;
      trigs += $countones(voice_trig);
    end
  endtask

  task automatic read_voice(input int v, input logic [31:0] exp);
    logic [31:0] e;
    @(negedge clk);
    address = v[1:0];
    rd_q.push_back(exp);
    @(posedge clk); #1;
    e = rd_q.pop_front();
    check($sformatf("readdata[%0d]", v), readdata, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int cyc;
    int tc;
    logic [4:0] n0, n1;

    tbl[0]  = '{32'(1<<5),                          4'b0001, {5'd0, 5'd0,  5'd0, 5'd5},  1};
    tbl[1]  = '{32'((1<<5)|(1<<7)),                 4'b0011, {5'd0, 5'd0,  5'd7, 5'd5},  1};
    tbl[2]  = '{32'(1<<7),                          4'b0010, {5'd0, 5'd0,  5'd7, 5'd5},  0};
    tbl[3]  = '{32'((1<<1)|(1<<7)),                 4'b0011, {5'd0, 5'd0,  5'd7, 5'd1},  1};
    tbl[4]  = '{32'((1<<1)|(1<<2)|(1<<7)),          4'b0111, {5'd0, 5'd2,  5'd7, 5'd1},  1};
    tbl[5]  = '{32'((1<<1)|(1<<2)|(1<<3)|(1<<7)),   4'b1111, {5'd3, 5'd2,  5'd7, 5'd1},  1};
    tbl[6]  = '{32'((1<<1)|(1<<2)|(1<<3)|(1<<7)|(1<<9)), 4'b1111, {5'd3, 5'd2, 5'd9, 5'd1}, 1};
    tbl[7]  = '{32'((1<<1)|(1<<2)|(1<<3)|(1<<9)),   4'b1111, {5'd3, 5'd2,  5'd9, 5'd1},  0};
    tbl[8]  = '{32'((1<<1)|(1<<3)|(1<<9)),          4'b1011, {5'd3, 5'd2,  5'd9, 5'd1},  0};
    tbl[9]  = '{32'((1<<1)|(1<<3)|(1<<9)|(1<<12)),  4'b1111, {5'd3, 5'd12, 5'd9, 5'd1},  1};
    tbl[10] = '{32'((1<<1)|(1<<3)|(1<<9)|(1<<12)|(1<<20)), 4'b1111, {5'd3, 5'd12, 5'd9, 5'd20}, 1};
    tbl[11] = '{32'((1<<1)|(1<<9)|(1<<12)|(1<<20)), 4'b0111, {5'd3, 5'd12, 5'd9, 5'd20}, 0};

    reset_n   = 1'b0;
    key_state = '0;
    scan_en   = 1'b1;
    all_off   = 1'b0;
    address   = '0;
    #1;
    check("reset_gate", {28'b0, voice_gate}, 32'h0);
    check("reset_trig", {28'b0, voice_trig}, 32'h0);
    check("reset_note", {12'b0, voice_note}, 32'h0);
    check("reset_readdata", readdata, 32'h0);

    // Key 5 from reset: 5 scan steps, then a 2-cycle event.
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    key_state = 32'(1<<5);
    cyc = 0;
    while (!voice_gate[0] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("press_latency", 32'(cyc), 32'd7);
    check("press_note0", {27'b0, note_of(0)}, 32'd5);
    check("press_trig", {28'b0, voice_trig}, 32'h1);
    @(posedge clk); #1;
    check("trig_one_cycle", {28'b0, voice_trig}, 32'h0);
    check("gate_held", {28'b0, voice_gate}, 32'h1);
    read_voice(0, 32'h25);

    // Reset asserted during the S_PRESS cycle of key 15 (keys 5,10 already allocated).
    @(negedge clk);
    reset_n = 1'b0;
    key_state = 32'((1<<5)|(1<<10)|(1<<15));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    check("pre_reset_gate", {28'b0, voice_gate}, 32'h3);
    reset_n = 1'b0;
    #1;
    check("midreset_gate", {28'b0, voice_gate}, 32'h0);
    check("midreset_note", {12'b0, voice_note}, 32'h0);
    check("midreset_trig", {28'b0, voice_trig}, 32'h0);
    check("midreset_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    settle(40, tc);
    check("redetect_gate", {28'b0, voice_gate}, 32'h7);
    check("redetect_note", {12'b0, voice_note}, {12'b0, 5'd0, 5'd15, 5'd10, 5'd5});
    check("redetect_trigs", 32'(tc), 32'd3);

    // Vector table from a clean reset.
    key_state = '0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      key_state = tbl[i].keys;
      settle(40, tc);
      check($sformatf("vec%0d_gate", i), {28'b0, voice_gate}, {28'b0, tbl[i].gate});
      check($sformatf("vec%0d_note", i), {12'b0, voice_note}, {12'b0, tbl[i].notes});
      check($sformatf("vec%0d_trigs", i), 32'(tc), 32'(tbl[i].trigs));
      for (int v = 0; v < 4; v++) begin
        read_voice(v, {26'b0, tbl[i].gate[v], tbl[i].notes[v*5 +: 5]});
      end
    end

    // Scanner frozen while key 3 toggles; one press once scanning resumes.
    @(negedge clk);
    scan_en = 1'b0;
    key_state[3] = 1'b1;
    settle(3, tc);
    key_state[3] = 1'b0;
    settle(3, cyc);
    tc += cyc;
    key_state[3] = 1'b1;
    settle(5, cyc);
    tc += cyc;
    check("frozen_gate", {28'b0, voice_gate}, 32'h7);
    check("frozen_trigs", 32'(tc), 32'd0);
    @(negedge clk);
    scan_en = 1'b1;
    settle(40, tc);
    check("resume_gate", {28'b0, voice_gate}, 32'hF);
    check("resume_trigs", 32'(tc), 32'd1);
    read_voice(3, 32'h23);

    // Panic with keys 2 and 6 held, then re-allocation within one scan.
    @(negedge clk);
    key_state = 32'((1<<2)|(1<<6));
    settle(80, tc);
    @(negedge clk);
    all_off = 1'b1;
    @(posedge clk); #1;
    check("alloff_gate", {28'b0, voice_gate}, 32'h0);
    check("alloff_trig", {28'b0, voice_trig}, 32'h0);
    @(negedge clk);
    all_off = 1'b0;
    cyc = 1;
    while (voice_gate != 4'b0011 && cyc < 36) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("realloc_gate", {28'b0, voice_gate}, 32'h3);
    n0 = note_of(0);
    n1 = note_of(1);
    check("realloc_notes", {31'b0, ((n0 == 5'd2 && n1 == 5'd6) || (n0 == 5'd6 && n1 == 5'd2))}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
